fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller between the instruction memory and the decode stage.
- Owns the program counter and drives the memory address; the memory returns data combinationally on that address.
- Registers the returned word into a valid/ready output stage and handles branch redirects, halt detection and resume.
- Holds off fetching for a boot window after reset, because the memory's contents are only valid after its first clock edge.

Parameters:
- MEMORY_DEPTH, 31, number of instruction words; the PC wraps modulo this value.
- BOOT_CYCLES, 2, clock cycles spent in BOOT after reset release before the first fetch (minimum 1).
- HALT_OPCODE, 5'b00110, value of instruction bits [31:27] that marks a halt instruction.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- instruction_address  output  32  address to instruction memory; always equals the PC.
- instruction_data_input  input  32  memory read data for instruction_address, same cycle.
- instruction_out  output  32  registered instruction presented to decode.
- instruction_pc  output  32  address instruction_out was fetched from.
- instruction_valid  output  1  instruction_out/instruction_pc hold a valid word.
- decode_ready  input  1  decode accepts the word this cycle.
- branch_taken  input  1  single-cycle redirect request from execute.
- branch_target  input  32  redirect address, sampled when branch_taken=1.
- resume  input  1  leave HALT and continue at the instruction after the halt.
- halted  output  1  high while in the HALT state.

Behaviour:
- Reset (reset_n=0, asynchronous) sets:
  - state=BOOT, PC=0, boot counter=0;
  - instruction_out=0, instruction_pc=0, instruction_valid=0, halted=0.
- Reset takes effect mid-operation too: any in-flight word is discarded.
- Accept condition: `accept = instruction_valid && decode_ready`. Load condition: `load = !instruction_valid || decode_ready`.
- BOOT:
  - Counts BOOT_CYCLES rising edges, then moves to FETCH. No capture happens in BOOT.
  - branch_taken and resume are ignored; instruction_valid stays 0.
- FETCH, one word per cycle maximum:
  - On a load cycle: instruction_out <= instruction_data_input, instruction_pc <= PC, instruction_valid <= 1, PC <= (PC+1 == MEMORY_DEPTH) ? 0 : PC+1.
  - If the captured word's bits [31:27] equal HALT_OPCODE, the next state is HALT. The halt word is still presented and must be accepted normally.
  - If not loading (valid && !decode_ready): hold all outputs and the PC (stall). Data must not change while valid && !ready.
  - If not loading and the word is accepted with nothing new loaded, instruction_valid <= 0. This cannot occur in FETCH; it applies only to HALT.
- HALT:
  - halted=1; no new capture.
  - An accept clears instruction_valid. Otherwise outputs hold.
  - resume=1 moves to FETCH next cycle; the PC is already halt address+1 (wrapped).
- branch_taken=1 in FETCH or HALT takes priority over load, halt detection and resume:
  - PC <= (branch_target < MEMORY_DEPTH) ? branch_target : 0;
  - instruction_valid <= 0 (flush; a word accepted in the same cycle counts as consumed);
  - state <= FETCH; halted <= 0.
  - The first post-branch word appears one cycle later: 1-cycle bubble.
- Simultaneous resume and branch_taken in HALT: the branch wins.
- Arithmetic: PC is 32 bits, compared and wrapped against MEMORY_DEPTH.
- Invariant: instruction_address == PC at all times.
- Latency: a word at the PC appears on instruction_out one edge after the cycle it is addressed, when the load condition holds.

Test Plan:
- Reset release, decode_ready=1, BOOT_CYCLES=2, memory word 0 = 0x20000000:
  - instruction_valid first rises after the 3rd edge post-release, with instruction_pc=0 and instruction_out=0x20000000;
  - instruction_pc then increments 1, 2, 3 on consecutive cycles.
- Backpressure: drop decode_ready for 3 cycles while holding word 5:
  - instruction_out, instruction_pc=5 and instruction_address=6 stay stable;
  - after ready rises, pc 6 follows on the next cycle.
- Branch: branch_taken=1 with branch_target=17 while word 23 is valid:
  - next cycle instruction_valid=0 and instruction_address=17;
  - following cycle instruction_pc=17.
  - Repeat with branch_target=40: PC becomes 0.
- Halt: word 26 = 0x30000000:
  - halted=1 after capture; the halt word is presented and accepted, then instruction_valid=0 and no further fetches for 10 cycles.
  - resume pulse: next captured instruction_pc=27.
- Wrap and collision:
  - fetch through pc=30; the next pc is 0.
  - In HALT, assert resume and branch_taken (target 10) together: the next instruction_pc is 10.
- Assert reset_n=0 mid-stall with valid=1: all outputs are 0 immediately, without waiting for a clock edge, and the BOOT sequence repeats.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch: owns the PC, captures one word per cycle into a valid/ready stage, handles branch/halt/resume.
// Latency: word appears one edge after it is addressed; stalls hold PC and outputs while valid && !decode_ready.
module fetch_sequencer #(
  parameter int unsigned MEMORY_DEPTH = 31,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter logic [4:0]  HALT_OPCODE  = 5'b00110
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] instruction_address,
  input  logic [31:0] instruction_data_input,
  output logic [31:0] instruction_out,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        decode_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        resume,
  output logic        halted
);

  localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HALT} state_t;

  state_t             state, state_nxt;
  logic [31:0]        pc, pc_nxt;
  logic [CNT_W-1:0]   boot_cnt, boot_cnt_nxt;
  logic [31:0]        out_dat, out_dat_nxt;
  logic [31:0]        out_pc, out_pc_nxt;
  logic               out_vld, out_vld_nxt;

  logic        accept;
  logic        load;
  logic [31:0] pc_inc;
  logic [31:0] branch_pc;

  assign accept    = out_vld && decode_ready;
  assign load      = !out_vld || decode_ready;
  assign pc_inc    = (pc + 32'd1 == 32'(MEMORY_DEPTH)) ? 32'd0 : pc + 32'd1;
  assign branch_pc = (branch_target < 32'(MEMORY_DEPTH)) ? branch_target : 32'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_BOOT;
      pc       <= '0;
      boot_cnt <= '0;
      out_dat  <= '0;
      out_pc   <= '0;
      out_vld  <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      boot_cnt <= boot_cnt_nxt;
      out_dat  <= out_dat_nxt;
      out_pc   <= out_pc_nxt;
      out_vld  <= out_vld_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    boot_cnt_nxt = boot_cnt;
    out_dat_nxt  = out_dat;
    out_pc_nxt   = out_pc;
    out_vld_nxt  = out_vld;
    case (state)
      ST_BOOT: begin
        // Memory contents become valid only after its first edge, so no capture here.
        if (boot_cnt == CNT_W'(BOOT_CYCLES - 1)) state_nxt = ST_FETCH;
        else                                     boot_cnt_nxt = boot_cnt + 1'b1;
      end
      ST_FETCH: begin
        if (branch_taken) begin
          pc_nxt      = branch_pc;
          out_vld_nxt = 1'b0;
        end else if (load) begin
          out_dat_nxt = instruction_data_input;
          out_pc_nxt  = pc;
          out_vld_nxt = 1'b1;
          pc_nxt      = pc_inc;
          if (instruction_data_input[31:27] == HALT_OPCODE) state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (branch_taken) begin
          pc_nxt      = branch_pc;
          out_vld_nxt = 1'b0;
          state_nxt   = ST_FETCH;
        end else begin
          if (accept) out_vld_nxt = 1'b0;
          if (resume) state_nxt = ST_FETCH;
        end
      end
      default: state_nxt = ST_BOOT;
    endcase
  end

  assign instruction_address = pc;
  assign instruction_out     = out_dat;
  assign instruction_pc      = out_pc;
  assign instruction_valid   = out_vld;
  assign halted              = (state == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a combinational instruction memory model.
module tb_fetch_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] instruction_address;
  logic [31:0] instruction_data_input;
  logic [31:0] instruction_out;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        decode_ready;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        resume;
  logic        halted;

  logic [31:0] mem [0:30];
  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign instruction_data_input = (instruction_address < 32'd31) ? mem[instruction_address[4:0]] : 32'd0;

  fetch_sequencer dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .instruction_address    (instruction_address),
    .instruction_data_input (instruction_data_input),
    .instruction_out        (instruction_out),
    .instruction_pc         (instruction_pc),
    .instruction_valid      (instruction_valid),
    .decode_ready           (decode_ready),
    .branch_taken           (branch_taken),
    .branch_target          (branch_target),
    .resume                 (resume),
    .halted                 (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Advance until the word at pc is presented, bounded by a cycle budget.
  task automatic wait_pc(input logic [31:0] pc);
    int n = 0;
    while (!(instruction_valid && instruction_pc == pc) && n < 100) begin
      step();
      n++;
    end
    check("wait_pc_reached", {31'd0, instruction_valid && instruction_pc == pc}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 31; i++) mem[i] = 32'h2000_0000 + 32'(i);
    mem[26] = 32'h3000_0000;
    reset_n = 1'b0; decode_ready = 1'b1; branch_taken = 1'b0;
    branch_target = 32'd0; resume = 1'b0;
    step(); step();
    check("rst_valid", {31'd0, instruction_valid}, 32'd0);
    check("rst_out", instruction_out, 32'd0);
    check("rst_pc", instruction_pc, 32'd0);
    check("rst_addr", instruction_address, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    reset_n = 1'b1;

    step(); check("boot_e1_valid", {31'd0, instruction_valid}, 32'd0);
    step(); check("boot_e2_valid", {31'd0, instruction_valid}, 32'd0);
    step();
    check("first_valid", {31'd0, instruction_valid}, 32'd1);
    check("first_pc", instruction_pc, 32'd0);
    check("first_out", instruction_out, 32'h2000_0000);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("seq_pc", instruction_pc, 32'(i));
    end

    // Backpressure on word 5.
    decode_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_out", instruction_out, 32'h2000_0005);
      check("stall_pc", instruction_pc, 32'd5);
      check("stall_addr", instruction_address, 32'd6);
      check("stall_valid", {31'd0, instruction_valid}, 32'd1);
    end
    decode_ready = 1'b1;
    step(); check("post_stall_pc", instruction_pc, 32'd6);

    // In-range branch.
    wait_pc(32'd23);
    branch_taken = 1'b1; branch_target = 32'd17;
    step(); branch_taken = 1'b0;
    check("br17_bubble", {31'd0, instruction_valid}, 32'd0);
    check("br17_addr", instruction_address, 32'd17);
    step();
    check("br17_valid", {31'd0, instruction_valid}, 32'd1);
    check("br17_pc", instruction_pc, 32'd17);

    // Out-of-range branch target falls back to 0.
    wait_pc(32'd23);
    branch_taken = 1'b1; branch_target = 32'd40;
    step(); branch_taken = 1'b0;
    check("br40_bubble", {31'd0, instruction_valid}, 32'd0);
    check("br40_addr", instruction_address, 32'd0);
    step(); check("br40_pc", instruction_pc, 32'd0);

    // Halt at word 26.
    wait_pc(32'd26);
    check("halt_flag", {31'd0, halted}, 32'd1);
    check("halt_word", instruction_out, 32'h3000_0000);
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_idle_valid", {31'd0, instruction_valid}, 32'd0);
      check("halt_idle_addr", instruction_address, 32'd27);
    end
    check("halt_still", {31'd0, halted}, 32'd1);
    resume = 1'b1;
    step(); resume = 1'b0;
    check("resume_halted", {31'd0, halted}, 32'd0);
    step();
    check("resume_valid", {31'd0, instruction_valid}, 32'd1);
    check("resume_pc", instruction_pc, 32'd27);
    for (int i = 28; i <= 30; i++) begin
      step(); check("tail_pc", instruction_pc, 32'(i));
    end
    step(); check("wrap_pc", instruction_pc, 32'd0);

    // Halt again; resume and branch together, branch wins.
    wait_pc(32'd26);
    step();
    resume = 1'b1; branch_taken = 1'b1; branch_target = 32'd10;
    step(); resume = 1'b0; branch_taken = 1'b0;
    check("coll_halted", {31'd0, halted}, 32'd0);
    check("coll_valid", {31'd0, instruction_valid}, 32'd0);
    check("coll_addr", instruction_address, 32'd10);
    step(); check("coll_pc", instruction_pc, 32'd10);

    // Asynchronous reset during a stall.
    decode_ready = 1'b0;
    step();
    check("pre_rst_valid", {31'd0, instruction_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, instruction_valid}, 32'd0);
    check("arst_out", instruction_out, 32'd0);
    check("arst_pc", instruction_pc, 32'd0);
    check("arst_addr", instruction_address, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    decode_ready = 1'b1;
    step(); step();
    reset_n = 1'b1;
    step(); check("reboot_e1_valid", {31'd0, instruction_valid}, 32'd0);
    step(); check("reboot_e2_valid", {31'd0, instruction_valid}, 32'd0);
    step();
    check("reboot_valid", {31'd0, instruction_valid}, 32'd1);
    check("reboot_pc", instruction_pc, 32'd0);
    check("reboot_out", instruction_out, 32'h2000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
